lutram_fifo_ctrl: RTL
=====================

Name: lutram_fifo_ctrl

Overview:
- Synchronous first-word-fall-through FIFO, 128 entries deep, built on distributed dual-port LUT RAM (DATA_W x RAM128X1D).
- The controller owns the write/read pointers, the occupancy counter, the flags and the valid/ready handshakes.
- It drives the RAM write port (A = write pointer, WE = push) and the async read port (DPRA = read pointer).
- Used as the standard small elastic buffer between streaming stages in the Verilator-simulated Xilinx designs.

Parameters:
- DATA_W, 8: entry width in bits; one RAM128X1D per bit.
- AFULL_THR, 96: AFULL asserts when LEVEL >= AFULL_THR; legal range 1..128.
- AEMPTY_THR, 8: AEMPTY asserts when LEVEL <= AEMPTY_THR; legal range 0..127.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- FLUSH  in  1  synchronous clear of pointers and level; RAM contents untouched.
- S_VALID  in  1  write side: data offered.
- S_READY  out  1  write side: FIFO can accept (= !FULL).
- S_DATA  in  DATA_W  write data.
- M_VALID  out  1  read side: head entry valid (= !EMPTY).
- M_READY  in  1  read side: consumer takes head.
- M_DATA  out  DATA_W  head entry, async read of RAM at the read pointer.
- LEVEL  out  8  occupancy, 0..128.
- FULL  out  1  LEVEL == 128.
- EMPTY  out  1  LEVEL == 0.
- AFULL  out  1  LEVEL >= AFULL_THR.
- AEMPTY  out  1  LEVEL <= AEMPTY_THR.

Behaviour:
- push = S_VALID & S_READY; pop = M_VALID & M_READY. Transfers happen only on rising CLK.
- All flags and LEVEL are registered state or decoded from registered state. S_READY and M_VALID have no combinational path from S_VALID or M_READY.
- Pointers wr_ptr and rd_ptr are 7 bits; each increments by 1 on push/pop and wraps 127 -> 0 naturally.
- LEVEL is 8 bits:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- Reset (RST=1): wr_ptr=0, rd_ptr=0, LEVEL=0, so EMPTY=1, FULL=0, S_READY=1, M_VALID=0, AEMPTY=1, AFULL=0. RAM contents are not cleared (no reset on LUT RAM).
- M_DATA is undefined while M_VALID=0; the bench must not check it then.
- Reset mid-operation: takes effect at that edge regardless of S_VALID/M_READY. Any push or pop in the same cycle is discarded and the RAM write is suppressed (WE = push & !RST & !FLUSH).
- FLUSH=1: same effect on pointers, level and flags as RST, with the same write suppression. RST has priority; both together equal a reset.
- Write-to-read latency:
  - Entry pushed at edge N into an empty FIFO gives M_VALID=1 after edge N; M_DATA equals that entry in cycle N+1.
  - No same-cycle bypass.
- Full: S_READY=0, so no push occurs even if S_VALID=1. A pop while full is allowed; S_READY returns to 1 the following cycle.
- Empty: M_VALID=0, so no pop occurs. A push while empty is allowed.
- Simultaneous push and pop at 0 < LEVEL < 128: both pointers advance and LEVEL holds. Write and read addresses differ, so there is no RAM collision.
- At LEVEL=128, wr_ptr == rd_ptr; the FIFO is full, so no write occurs and the head is unharmed.
- Throughput: one push and one pop per cycle sustained.
- No internal state machine beyond the counters. The controller is a 3-way update (reset/flush, normal, idle) per cycle.

Decomposition:
- Package lutram_fifo_pkg:
  - FIFO_DEPTH=128, PTR_W=7, LVL_W=8.
  - Function next_ptr (7-bit wrap increment).
- One sub-module, ram128xn_dp: parameter DATA_W, ports WCLK/WE/A/DPRA/D[DATA_W]/DPO[DATA_W].
  - Generate loop of RAM128X1D, INIT=0, IS_WCLK_INVERTED=0.
  - SPO left unconnected.
- The controller instantiates ram128xn_dp once and contains all pointer/level/flag logic.

Test Plan:
1. Reset then idle -> LEVEL=0, EMPTY=1, S_READY=1, M_VALID=0, AEMPTY=1, FULL=0, AFULL=0.
2. Push 0x11,0x22,0x33 back-to-back, M_READY=0:
   - M_VALID rises the cycle after the first push with M_DATA=0x11; LEVEL=3.
   - Then M_READY=1 for 3 cycles gives 0x11, 0x22, 0x33 in order, then EMPTY=1.
3. Push 128 entries (values 0..127) with M_READY=0:
   - AFULL asserts after push 96, FULL/S_READY=0 after push 128.
   - A 129th S_VALID is ignored (LEVEL stays 128).
   - Draining returns 0..127 exactly, proving pointer wrap.
4. At LEVEL=64, hold S_VALID=M_READY=1 for 200 cycles with incrementing data:
   - LEVEL stays 64, no gaps in output sequence.
   - Pointers wrap at least once.
5. At FULL, assert M_READY=1 and S_VALID=1 together:
   - The pop occurs and the push is blocked, so LEVEL=127.
   - The next cycle S_READY=1 and the push succeeds, so LEVEL back to 128.
6. At LEVEL=50, assert FLUSH (then separately RST) with S_VALID=M_READY=1:
   - Next cycle LEVEL=0, EMPTY=1, no transfer counted.
   - A subsequent push 0xA5 appears as the first M_DATA.

Source files
------------

// File: rtl/lutram_fifo_pkg.sv
// Shared sizing, update-kind encoding and pointer helper for the LUT-RAM FIFO.
package lutram_fifo_pkg;

  localparam int unsigned FIFO_DEPTH = 128;
  localparam int unsigned PTR_W      = 7;
  localparam int unsigned LVL_W      = 8;

  typedef enum logic [1:0] {
    UPD_IDLE   = 2'd0,
    UPD_NORMAL = 2'd1,
    UPD_CLEAR  = 2'd2
  } upd_e;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/RAM128X1D.sv
// Behavioural model of the Xilinx RAM128X1D primitive: 128x1 distributed RAM,
// synchronous write on A, async reads on A (SPO) and DPRA (DPO).
module RAM128X1D #(
  parameter logic [127:0] INIT             = '0,
  parameter logic         IS_WCLK_INVERTED = 1'b0
) (
  output logic       DPO,
  output logic       SPO,
  input  logic [6:0] A,
  input  logic       D,
  input  logic [6:0] DPRA,
  input  logic       WCLK,
  input  logic       WE
);

  logic [127:0] mem = INIT;
  logic         wclk_int;

  assign wclk_int = WCLK ^ IS_WCLK_INVERTED;

  always_ff @(posedge wclk_int) begin
    if (WE) mem[A] <= D;
  end

  assign SPO = mem[A];
  assign DPO = mem[DPRA];

endmodule

// File: rtl/ram128xn_dp.sv
// DATA_W-wide 128-deep dual-port distributed RAM, one RAM128X1D per bit.
module ram128xn_dp #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              WCLK,
  input  logic              WE,
  input  logic [6:0]        A,
  input  logic [6:0]        DPRA,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] DPO
);

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    RAM128X1D #(
      .INIT            (128'h0),
      .IS_WCLK_INVERTED(1'b0)
    ) u_ram (
      .DPO (DPO[i]),
      .SPO (),
      .A   (A),
      .D   (D[i]),
      .DPRA(DPRA),
      .WCLK(WCLK),
      .WE  (WE)
    );
  end

endmodule

// File: rtl/lutram_fifo_ctrl.sv
// 128-entry first-word-fall-through FIFO controller over distributed LUT RAM:
// owns pointers, occupancy, flags and the valid/ready handshakes.
module lutram_fifo_ctrl
  import lutram_fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned AFULL_THR  = 96,
  parameter int unsigned AEMPTY_THR = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [DATA_W-1:0] S_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [DATA_W-1:0] M_DATA,
  output logic [7:0]        LEVEL,
  output logic              FULL,
  output logic              EMPTY,
  output logic              AFULL,
  output logic              AEMPTY
);

  localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] AFULL_LVL  = LVL_W'(AFULL_THR);
  localparam logic [LVL_W-1:0] AEMPTY_LVL = LVL_W'(AEMPTY_THR);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             push;
  logic             pop;
  logic             ram_we;
  upd_e             upd;

  // Flags decode only registered level, so ready/valid never see S_VALID/M_READY.
  assign FULL    = (level == FULL_LVL);
  assign EMPTY   = (level == '0);
  assign AFULL   = (level >= AFULL_LVL);
  assign AEMPTY  = (level <= AEMPTY_LVL);
  assign S_READY = !FULL;
  assign M_VALID = !EMPTY;
  assign LEVEL   = level;

  assign push   = S_VALID & S_READY;
  assign pop    = M_VALID & M_READY;
  assign ram_we = push & !RST & !FLUSH;

  always_comb begin
    upd = UPD_IDLE;
    if (RST || FLUSH)  upd = UPD_CLEAR;
    else if (push || pop) upd = UPD_NORMAL;
  end

  always_ff @(posedge CLK) begin
    case (upd)
      UPD_CLEAR: begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end
      UPD_NORMAL: begin
        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
        if (push && !pop)      level <= level + 1'b1;
        else if (pop && !push) level <= level - 1'b1;
      end
      default: ;
    endcase
  end

  ram128xn_dp #(
    .DATA_W(DATA_W)
  ) u_ram (
    .WCLK(CLK),
    .WE  (ram_we),
    .A   (wr_ptr),
    .DPRA(rd_ptr),
    .D   (S_DATA),
    .DPO (M_DATA)
  );

endmodule
